// File: rtl/note_sched_pkg.sv
// note_sched_pkg
// Shared definitions for the song playback controller:
//   - state_t     : playback FSM states
//   - SILENT_DIV  : divider value that keeps the square-wave generator quiet
//   - ROM word layout {div_left[47:26], div_right[25:4], dur[3:0]} and
//     small helpers that pull the fields out of a word.
package note_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4,
        PAUSE = 3'd5
    } state_t;

    localparam int DIV_W  = 22;
    localparam int DUR_W  = 4;
    localparam int WORD_W = 48;

    localparam int DIV_LEFT_LSB  = 26;
    localparam int DIV_RIGHT_LSB = 4;
    localparam int DUR_LSB       = 0;

    localparam logic [DIV_W-1:0] SILENT_DIV = 22'd1;

    function automatic logic [DIV_W-1:0] word_div_left(input logic [WORD_W-1:0] w);
        return w[DIV_LEFT_LSB +: DIV_W];
    endfunction

    function automatic logic [DIV_W-1:0] word_div_right(input logic [WORD_W-1:0] w);
        return w[DIV_RIGHT_LSB +: DIV_W];
    endfunction

    function automatic logic [DUR_W-1:0] word_dur(input logic [WORD_W-1:0] w);
        return w[DUR_LSB +: DUR_W];
    endfunction

endpackage

// File: rtl/note_scheduler_beat_timer.sv
// beat_timer
// Tick counter that runs 0..BEAT_DIV-1 while enabled and flags the wrap.
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-high reset
//   en    in  advance the tick counter this cycle
//   clr   in  force the tick counter back to 0 (wins over en)
//   beat  out one-cycle pulse in the cycle the counter wraps
// The beat pulse is combinational from the current count and en so the
// owning FSM can act on the wrap in the same cycle; it deliberately does not
// depend on clr, which keeps the parent's clear logic free of loops.
module beat_timer #(
    parameter int BEAT_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic beat
);

    localparam int TICK_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BEAT_DIV - 1);

    logic [TICK_W-1:0] tick_q;
    logic [TICK_W-1:0] tick_d;

    assign beat = en && (tick_q == TICK_LAST);

    always_comb begin
        tick_d = tick_q;
        if (clr) begin
            tick_d = '0;
        end else if (en) begin
            tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/note_scheduler.sv
// note_scheduler
// Steps through a song ROM at a fixed beat rate, drives the note generator's
// left/right dividers, inserts a silent gap after each note and supports
// pause/resume/stop. In IDLE the divider outputs follow the live keyboard.
// Optional build macro: KEY_OVERRIDE_EN -- when defined, key_valid replaces
// the outputs with the keyboard dividers in every non-IDLE state as well
// (the sequencer keeps running underneath).
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   play_start/play_stop          single-cycle start / abort pulses
//   pause_toggle                  single-cycle pause enter/leave pulse
//   key_valid, key_div_left/right keyboard request and dividers
//   rom_addr / rom_data           song ROM port (1-cycle read latency)
//   note_div_left/right           registered dividers (1 = silent)
//   playing                       registered, high outside IDLE
//   done                          one-cycle pulse on normal song end
module note_scheduler
    import note_sched_pkg::*;
#(
    parameter int BEAT_DIV = 25_000_000,
    parameter int GAP_CYC  = 2_500_000,
    parameter int SONG_LEN = 64,
    parameter int ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play_start,
    input  logic              play_stop,
    input  logic              pause_toggle,
    input  logic              key_valid,
    input  logic [DIV_W-1:0]  key_div_left,
    input  logic [DIV_W-1:0]  key_div_right,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_data,
    output logic [DIV_W-1:0]  note_div_left,
    output logic [DIV_W-1:0]  note_div_right,
    output logic              playing,
    output logic              done
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

    state_t             state_q, state_d;
    state_t             saved_q, saved_d;
    logic [DUR_W-1:0]   beats_q, beats_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DIV_W-1:0]   song_l_q, song_l_d;
    logic [DIV_W-1:0]   song_r_q, song_r_d;
    logic [DIV_W-1:0]   out_l_q, out_l_d;
    logic [DIV_W-1:0]   out_r_q, out_r_d;
    logic               playing_q, playing_d;
    logic               done_q, done_d;

    logic               stop_evt;
    logic               pause_evt;
    logic               timer_en;
    logic               timer_clr;
    logic               beat;

    // Stop outranks pause, pause outranks the normal advance.
    assign stop_evt  = play_stop && (state_q != IDLE);
    assign pause_evt = pause_toggle && (state_q == HOLD || state_q == GAP);

    // The tick only advances in HOLD cycles that are not pre-empted, so a
    // pause entered at tick N resumes at tick N.
    assign timer_en  = (state_q == HOLD) && !play_stop && !pause_toggle;
    assign timer_clr = (state_q == IDLE) || (state_q == LOAD) || stop_evt;

    beat_timer #(
        .BEAT_DIV (BEAT_DIV)
    ) u_beat_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (timer_en),
        .clr  (timer_clr),
        .beat (beat)
    );

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            saved_q   <= IDLE;
            beats_q   <= '0;
            gap_q     <= '0;
            addr_q    <= '0;
            song_l_q  <= SILENT_DIV;
            song_r_q  <= SILENT_DIV;
            out_l_q   <= SILENT_DIV;
            out_r_q   <= SILENT_DIV;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            saved_q   <= saved_d;
            beats_q   <= beats_d;
            gap_q     <= gap_d;
            addr_q    <= addr_d;
            song_l_q  <= song_l_d;
            song_r_q  <= song_r_d;
            out_l_q   <= out_l_d;
            out_r_q   <= out_r_d;
            playing_q <= playing_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        saved_d  = saved_q;
        beats_d  = beats_q;
        gap_d    = gap_q;
        addr_d   = addr_q;
        song_l_d = song_l_q;
        song_r_d = song_r_q;
        done_d   = 1'b0;

        if (stop_evt) begin
            state_d = IDLE;
            beats_d = '0;
            gap_d   = '0;
        end else if (pause_evt) begin
            state_d = PAUSE;
            saved_d = state_q;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (play_start) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    state_d = LOAD;
                end
                LOAD: begin
                    if (word_dur(rom_data) == '0) begin
                        // End-of-song marker.
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        song_l_d = word_div_left(rom_data);
                        song_r_d = word_div_right(rom_data);
                        beats_d  = word_dur(rom_data);
                        state_d  = HOLD;
                    end
                end
                HOLD: begin
                    if (beat) begin
                        beats_d = beats_q - DUR_W'(1);
                        if (beats_q == DUR_W'(1)) begin
                            state_d = GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        gap_d = '0;
                        if (addr_q == ADDR_LAST) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = FETCH;
                        end
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                PAUSE: begin
                    if (pause_toggle) begin
                        state_d = saved_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Every way back to IDLE rewinds the song pointer.
        if (state_d == IDLE) begin
            addr_d = '0;
        end
    end

    // Output selection, evaluated on the next state so the registered
    // outputs line up with the state they describe.
    always_comb begin
        out_l_d   = SILENT_DIV;
        out_r_d   = SILENT_DIV;
        playing_d = (state_d != IDLE);

        unique case (state_d)
            IDLE: begin
                if (key_valid) begin
                    out_l_d = key_div_left;
                    out_r_d = key_div_right;
                end
            end
            HOLD: begin
                out_l_d = song_l_d;
                out_r_d = song_r_d;
            end
            default: begin
                out_l_d = SILENT_DIV;
                out_r_d = SILENT_DIV;
            end
        endcase

`ifdef KEY_OVERRIDE_EN
        if (state_d != IDLE && key_valid) begin
            out_l_d = key_div_left;
            out_r_d = key_div_right;
        end
`endif
    end

    assign rom_addr       = addr_q;
    assign note_div_left  = out_l_q;
    assign note_div_right = out_r_q;
    assign playing        = playing_q;
    assign done           = done_q;

endmodule

// File: doc/note_scheduler.md
# note_scheduler

Playback controller and channel arbiter in front of the square-wave note generator. Steps through a song ROM at a fixed beat rate and drives the generator's left and right note dividers. Inserts a silent articulation gap after every note and supports pause, resume and stop. When idle, it hands the divider channels to the live keyboard path.

## Interface
- BEAT_DIV, 25_000_000, clk cycles per beat (≥2).
- GAP_CYC, 2_500_000, clk cycles of silence after each note (≥1).
- SONG_LEN, 64, number of ROM entries; addresses 0..SONG_LEN-1.
- ADDR_W, 6, ROM address width (2^ADDR_W ≥ SONG_LEN).
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- play_start  in  1  single-cycle pulse; starts playback from address 0.
- play_stop  in  1  single-cycle pulse; aborts playback.
- pause_toggle  in  1  single-cycle pulse; enters or leaves pause.
- key_valid  in  1  keyboard is requesting the channels.
- key_div_left, key_div_right  in  22 each  keyboard dividers.
- rom_addr  out  ADDR_W  song ROM address.
- rom_data  in  48  {div_left[47:26], div_right[25:4], dur[3:0]}; valid 1 cycle after rom_addr.
- note_div_left, note_div_right  out  22 each  dividers to the generator; 22'd1 = silent.
- playing  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a song ends normally.

## Operation
- Reset values: note_div_* = 1, rom_addr = 0, playing = 0, done = 0, state IDLE, all counters 0.
- States and transitions:
  - IDLE: exits to FETCH on play_start; rom_addr forced to 0.
  - FETCH: one cycle, address stable; goes to LOAD.
  - LOAD: captures rom_data.
    - dur = 0 is the end-of-song marker: go to IDLE and pulse done.
    - Otherwise latch div_left and div_right, load beats_left = dur, clear the tick counter, go to HOLD.
  - HOLD: the tick counter runs 0..BEAT_DIV-1. On wrap, beats_left decrements. When the last beat wraps, go to GAP. HOLD therefore lasts exactly dur×BEAT_DIV cycles.
  - GAP: outputs silent for GAP_CYC cycles, then:
    - rom_addr = SONG_LEN-1: rom_addr wraps to 0, go to IDLE and pulse done.
    - Otherwise increment rom_addr and go to FETCH.
  - PAUSE: entered from HOLD or GAP on pause_toggle; the interrupted state is saved. Tick, beat and gap counters are frozen and outputs are silent. The next pause_toggle returns to the saved state with counters unchanged.
- pause_toggle in IDLE, FETCH or LOAD is ignored.
- Event priority in the same cycle: play_stop > pause_toggle > normal advance.
  - play_stop in any non-IDLE state: go to IDLE with no done pulse. rom_addr resets to 0.
  - play_start outside IDLE is ignored.
- Output selection, registered:
  - IDLE: key dividers if key_valid, else 1.
  - HOLD: latched song dividers.
  - FETCH, LOAD, GAP and PAUSE: 1.
- A ROM divider value of 1 is a rest on that channel and is passed through unchanged.
- Width rules:
  - Tick counter is $clog2(BEAT_DIV) bits and gap counter is $clog2(GAP_CYC) bits; neither ever counts past its terminal value.
  - beats_left is 4 bits.

## Timing
- All outputs are registered. A state change in cycle N becomes visible on note_div_*, playing and done in cycle N+1.
- ROM read latency is fixed at 1 cycle, so rom_data is sampled in LOAD.
- Per-note period = 2 + dur×BEAT_DIV + GAP_CYC cycles, excluding pause time.
- play_start to first audible divider: 3 cycles (FETCH, LOAD, then the output register).
- key_valid to key divider at output in IDLE: 1 cycle.
- Reset asserted mid-song: outputs take reset values immediately (asynchronous).

## Configuration
- KEY_OVERRIDE_EN defined: in every non-IDLE state, key_valid=1 replaces the output with key_div_left and key_div_right. The sequencer keeps counting underneath. Release returns the outputs to the state-selected value on the next cycle.
- Not defined: key inputs are ignored outside IDLE.

## Structure
- Package note_sched_pkg holds:
  - the state enum (IDLE, FETCH, LOAD, HOLD, GAP, PAUSE);
  - SILENT_DIV = 22'd1;
  - the ROM word field offsets and widths (DIV_W = 22, DUR_W = 4, WORD_W = 48).
- One sub-module, beat_timer, contains the tick counter. It takes enable and clear inputs and emits a one-cycle beat pulse on wrap. note_scheduler owns the FSM, beats_left, the gap counter and the output mux.

## Test plan
All scenarios use BEAT_DIV=4, GAP_CYC=2, SONG_LEN=4.
- Reset: assert rst mid-HOLD → note_div_left = note_div_right = 1, playing = 0 and rom_addr = 0 in the same cycle.
- Single note: ROM[0] = {191113, 151686, 2}, ROM[1].dur = 0, pulse play_start → outputs 191113/151686 for exactly 8 cycles, then 1 for 2 + 2 cycles, then done high for 1 cycle and playing low.
- Pause: pause_toggle at HOLD tick 1 of beat 0, wait 10 cycles, toggle again → outputs 1 for the pause interval. The remaining HOLD time is 7 cycles and the note ends 10+1 cycles later than the unpaused run.
- Stop: play_stop during GAP of note 1 → IDLE the next cycle, no done pulse, rom_addr = 0, outputs silent (key_valid = 0).
- Wrap: all four entries dur = 1 → four notes of 4 cycles each, done after address 3, rom_addr returns to 0.
- Keys: key_valid with 22'd227272 in IDLE → output 227272 after 1 cycle. During HOLD → 227272 with KEY_OVERRIDE_EN defined, song divider without it.
